// File: rtl/uart_pkg.sv
// Purpose: shared UART types and sizes for the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_FIFO_DEPTH_LOG2 = 5;
   localparam int UART_BAUD_DIV_W      = 16;

   // Transmit bit-timing FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Purpose: circular byte queue with registered pointers; one slot kept free to tell full from empty.
// Latency: a write at edge N is visible on rdata_o/empty_o after edge N; read data is combinational.
// Backpressure: full_o high drops writes; re_i must only be asserted while !empty_o.
module uart_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] read_ptr;
   logic [DEPTH_LOG2-1:0] write_ptr;
   logic [DEPTH_LOG2-1:0] write_ptr_inc;
   logic                  push;

   // Pointers wrap naturally modulo the depth
   assign write_ptr_inc = write_ptr + 1'b1;
   assign empty_o       = (read_ptr == write_ptr);
   assign full_o        = (write_ptr_inc == read_ptr);
   assign push          = we_i && !full_o;
   assign rdata_o       = mem[read_ptr];

   // Storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[write_ptr] <= wdata_i;
      end
   end

   // Pointer update; push and pop in the same cycle are both honoured
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         read_ptr  <= '0;
         write_ptr <= '0;
      end else begin
         if (push) begin
            write_ptr <= write_ptr_inc;
         end
         if (re_i) begin
            read_ptr <= read_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Purpose: buffered UART transmitter, 32-entry queue feeding an 8N1 serialiser (8N2 with UART_TX_STOP2_EN).
// Latency: byte written at edge N starts its start bit at edge N+1; frame = 10 (11 with 8N2) bit periods.
// Backpressure: full_o drops writes; stall_i high holds off new frames, never truncates a running one.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [UART_BAUD_DIV_W-1:0] baud_div_i,
   input  logic                       we_i,
   input  logic [UART_DATA_W-1:0]     data_i,
   input  logic                       stall_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       busy_o,
   output logic                       tx_o
);

   uart_tx_state_e             state;
   logic [UART_BAUD_DIV_W-1:0] counter;
   logic [UART_DATA_W-1:0]     shift_r;
   logic [2:0]                 bit_idx;
   logic [UART_DATA_W-1:0]     fifo_rdata;
   logic                       pop;
   logic                       bit_end;
`ifdef UART_TX_STOP2_EN
   logic                       stop2_r;
`endif

   uart_fifo #(
      .DATA_W     (UART_DATA_W),
      .DEPTH_LOG2 (UART_FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we_i),
      .wdata_i (data_i),
      .re_i    (pop),
      .rdata_o (fifo_rdata),
      .full_o  (full_o),
      .empty_o (empty_o)
   );

   // A frame may only start from IDLE; stall_i is looked at nowhere else
   assign pop     = (state == IDLE) && !empty_o && !stall_i;
   // >= keeps a lowered baud_div_i mid-bit from running the counter past the end
   assign bit_end = (counter >= baud_div_i);

   // Bit-timing FSM with registered line and busy outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         counter <= '0;
         shift_r <= '0;
         bit_idx <= '0;
         tx_o    <= 1'b1;
         busy_o  <= 1'b0;
`ifdef UART_TX_STOP2_EN
         stop2_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state   <= START;
                  shift_r <= fifo_rdata;
                  counter <= '0;
                  tx_o    <= 1'b0;
                  busy_o  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  counter <= '0;
                  bit_idx <= '0;
                  tx_o    <= shift_r[0];
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  counter <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_o  <= 1'b1;
                  end else begin
                     shift_r <= shift_r >> 1;
                     tx_o    <= shift_r[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  counter <= '0;
`ifdef UART_TX_STOP2_EN
                  if (!stop2_r) begin
                     stop2_r <= 1'b1;
                  end else begin
                     stop2_r <= 1'b0;
                     state   <= IDLE;
                     busy_o  <= 1'b0;
                  end
`else
                  state  <= IDLE;
                  busy_o <= 1'b0;
`endif
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Purpose: directed self-checking bench for the buffered UART transmitter.
// Latency: frames checked cycle by cycle against a bench-built 8N1/8N2 waveform.
// Backpressure: exercises stall_i holding, queue full/drop and back-to-back frames.
module tb_uart_tx_fifo_ctrl;

`ifdef UART_TX_STOP2_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [15:0] baud_div_i = 16'd3;
   logic        we_i = 1'b0;
   logic [7:0]  data_i = 8'd0;
   logic        stall_i = 1'b0;
   logic        full_o;
   logic        empty_o;
   logic        busy_o;
   logic        tx_o;

   int errors = 0;
   int checks = 0;
   int last_wait = 0;

   uart_tx_fifo_ctrl dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .baud_div_i (baud_div_i),
      .we_i       (we_i),
      .data_i     (data_i),
      .stall_i    (stall_i),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .busy_o     (busy_o),
      .tx_o       (tx_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      we_i   = 1'b1;
      data_i = b;
      step();
      we_i   = 1'b0;
   endtask

   // Wait up to max_wait cycles for a start bit, then compare every cycle of the frame
   task automatic frame(input logic [7:0] b, input int div, input int max_wait, input string tag);
      int waited = 0;
      int bad = 0;
      int len;
      int bitno;
      logic exp;
      logic [7:0] got = 8'h00;
      while (tx_o !== 1'b0 && waited < max_wait) begin
         step();
         waited++;
      end
      last_wait = waited;
      check({tag, "_start"}, {31'd0, tx_o}, 32'd0);
      if (tx_o !== 1'b0) return;
      len = (9 + NSTOP) * (div + 1);
      for (int k = 0; k < len; k++) begin
         bitno = k / (div + 1);
         if (bitno == 0) exp = 1'b0;
         else if (bitno <= 8) exp = b[bitno-1];
         else exp = 1'b1;
         if (tx_o !== exp) bad++;
         if (bitno >= 1 && bitno <= 8 && (k % (div + 1)) == div / 2) got[bitno-1] = tx_o;
         if (k == len - 1) check({tag, "_busy_last"}, {31'd0, busy_o}, 32'd1);
         step();
      end
      check({tag, "_bad_cycles"}, bad, 0);
      check({tag, "_data"}, {24'd0, got}, {24'd0, b});
      check({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int bad;

      // Reset state
      #12;
      check("rst_tx", {31'd0, tx_o}, 32'd1);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_empty", {31'd0, empty_o}, 32'd1);
      check("rst_full", {31'd0, full_o}, 32'd0);
      #5 rst_ni = 1'b1;
      step();
      step();

      // Single byte 0xA5 at 4 cycles per bit
      baud_div_i = 16'd3;
      write_byte(8'hA5);
      check("single_empty_after_write", {31'd0, empty_o}, 32'd0);
      frame(8'hA5, 3, 2, "single");
      check("single_wait", last_wait, 1);
      check("single_empty_end", {31'd0, empty_o}, 32'd1);
      step();
      step();

      // Back-to-back frames with exactly one idle cycle between them
      baud_div_i = 16'd1;
      write_byte(8'h00);
      write_byte(8'hFF);
      frame(8'h00, 1, 2, "b2b0");
      check("b2b_idle_tx", {31'd0, tx_o}, 32'd1);
      frame(8'hFF, 1, 1, "b2b1");
      check("b2b_gap", last_wait, 1);
      check("b2b_empty", {31'd0, empty_o}, 32'd1);
      step();

      // Full and drop: 31 usable entries
      baud_div_i = 16'd0;
      stall_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         write_byte(i[7:0]);
         if (i == 29) check("full_after_30", {31'd0, full_o}, 32'd0);
         if (i == 30) check("full_after_31", {31'd0, full_o}, 32'd1);
      end
      check("full_after_32", {31'd0, full_o}, 32'd1);
      check("full_busy_stalled", {31'd0, busy_o}, 32'd0);
      stall_i = 1'b0;
      for (int i = 0; i < 31; i++) begin
         frame(i[7:0], 0, 1, $sformatf("drain%0d", i));
      end
      check("drain_empty", {31'd0, empty_o}, 32'd1);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
         step();
      end
      check("dropped_no_frame", bad, 0);

      // Stall holds the line idle, release starts the frame on the next edge
      baud_div_i = 16'd3;
      stall_i = 1'b1;
      write_byte(8'h3C);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
         step();
      end
      check("stall_hold", bad, 0);
      stall_i = 1'b0;
      frame(8'h3C, 3, 1, "stall_rel");
      check("stall_rel_wait", last_wait, 1);
      step();

      // 0x81 at 4 cycles per bit: 40 cycles (44 with two stop bits)
      write_byte(8'h81);
      frame(8'h81, 3, 2, "b81");
      step();

      // Asynchronous reset during data bit 3 of 0x55, with a second byte queued
      write_byte(8'h55);
      write_byte(8'h12);
      for (int k = 0; k < 17; k++) step();
      check("mid_bit3_low", {31'd0, tx_o}, 32'd0);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_tx", {31'd0, tx_o}, 32'd1);
      check("arst_empty", {31'd0, empty_o}, 32'd1);
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      #3 rst_ni = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
      end
      check("arst_queue_lost", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
